// File: rtl/alu_comparator_serial.sv
// Serial magnitude comparator: compares CHUNK bits per cycle, MSB chunk first, with a valid/ready handshake.
// Optional build macro ALU_COMPARATOR_EARLY_EXIT_EN finishes as soon as the first differing chunk is found.
module alu_comparator_serial #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             eq,
  output logic             greater,
  output logic             less,
  output logic             busy
);

  localparam int NCH   = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] MSB_MASK = ~({WIDTH{1'b1}} >> 1);

  generate
    if ((WIDTH <= 0) || (CHUNK <= 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
      $error("alu_comparator_serial: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [IDX_W-1:0]   idx_r, idx_s;
  logic [WIDTH-1:0]   a_r, a_s, b_r, b_s;
  logic               eq_acc_r, eq_acc_s;
  logic               gt_acc_r, gt_acc_s;
  logic [CHUNK-1:0]   chunk_a_s, chunk_b_s;
  logic               last_s;

  logic start_ready_r, result_valid_r, busy_r, eq_r, greater_r, less_r;

  // Operands are shifted left each cycle, so the chunk under test is always the top one.
  assign chunk_a_s = a_r[WIDTH-1 -: CHUNK];
  assign chunk_b_s = b_r[WIDTH-1 -: CHUNK];

  // Decide whether the chunk being processed this cycle ends the compare.
  always_comb begin
    last_s = (idx_r == IDX_W'(0));
`ifdef ALU_COMPARATOR_EARLY_EXIT_EN
    if (eq_acc_r && (chunk_a_s != chunk_b_s)) begin
      last_s = 1'b1;
    end else begin
      last_s = (idx_r == IDX_W'(0));
    end
`endif
  end

  // Next-state, operand shift and accumulator update.
  always_comb begin
    state_s  = state_r;
    idx_s    = idx_r;
    a_s      = a_r;
    b_s      = b_r;
    eq_acc_s = eq_acc_r;
    gt_acc_s = gt_acc_r;
    case (state_r)
      IDLE: begin
        if (start_valid) begin
          state_s  = COMPARE;
          idx_s    = IDX_W'(NCH - 1);
          a_s      = a ^ (signed_mode ? MSB_MASK : {WIDTH{1'b0}});
          b_s      = b ^ (signed_mode ? MSB_MASK : {WIDTH{1'b0}});
          eq_acc_s = 1'b1;
          gt_acc_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      COMPARE: begin
        a_s = a_r << CHUNK;
        b_s = b_r << CHUNK;
        if (eq_acc_r) begin
          eq_acc_s = (chunk_a_s == chunk_b_s);
          gt_acc_s = (chunk_a_s > chunk_b_s);
        end else begin
          eq_acc_s = eq_acc_r;
          gt_acc_s = gt_acc_r;
        end
        if (last_s) begin
          state_s = DONE;
        end else begin
          idx_s = idx_r - IDX_W'(1);
        end
      end
      DONE: begin
        if (result_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= IDLE;
      idx_r          <= IDX_W'(0);
      a_r            <= {WIDTH{1'b0}};
      b_r            <= {WIDTH{1'b0}};
      eq_acc_r       <= 1'b1;
      gt_acc_r       <= 1'b0;
      start_ready_r  <= 1'b1;
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      eq_r           <= 1'b0;
      greater_r      <= 1'b0;
      less_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      idx_r          <= idx_s;
      a_r            <= a_s;
      b_r            <= b_s;
      eq_acc_r       <= eq_acc_s;
      gt_acc_r       <= gt_acc_s;
      start_ready_r  <= (state_s == IDLE);
      result_valid_r <= (state_s == DONE);
      busy_r         <= (state_s == COMPARE);
      eq_r           <= (state_s == DONE) && eq_acc_s;
      greater_r      <= (state_s == DONE) && gt_acc_s;
      less_r         <= (state_s == DONE) && !eq_acc_s && !gt_acc_s;
    end
  end

  assign start_ready  = start_ready_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign eq           = eq_r;
  assign greater      = greater_r;
  assign less         = less_r;

endmodule

// File: tb/tb_alu_comparator_serial.sv
// Directed self-checking bench for alu_comparator_serial (WIDTH=16, CHUNK=4); expected values are hand-computed.
module tb_alu_comparator_serial;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        signed_mode;
  logic        result_valid;
  logic        result_ready;
  logic        eq;
  logic        greater;
  logic        less;
  logic        busy;

  int checks = 0;
  int failures = 0;

`ifdef ALU_COMPARATOR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  alu_comparator_serial dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .signed_mode  (signed_mode),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .eq           (eq),
    .greater      (greater),
    .less         (less),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one request, then wait for result_valid (bounded) while scrambling the inputs.
  task automatic start_and_wait(input logic [15:0] va, input logic [15:0] vb, input logic sm,
                                input logic rr, output int lat);
    a = va; b = vb; signed_mode = sm; start_valid = 1'b1; result_ready = rr;
    tick();
    start_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      a = 16'($urandom); b = 16'($urandom); signed_mode = 1'($urandom);
      tick();
      if (result_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_cmp(input string tag, input logic [15:0] va, input logic [15:0] vb, input logic sm,
                         input logic [2:0] exp_egl, input int k_early);
    int lat;
    start_and_wait(va, vb, sm, 1'b1, lat);
    check({tag, "_lat"}, lat, EARLY ? k_early : 4);
    check({tag, "_egl"}, {eq, greater, less}, exp_egl);
    tick();
    check({tag, "_idle"}, {start_ready, result_valid, busy, eq, greater, less}, 6'b100000);
  endtask

  initial begin
    int lat;
    reset = 1'b1; start_valid = 1'b1; a = 16'h0001; b = 16'h0002;
    signed_mode = 1'b0; result_ready = 1'b1;
    tick();
    tick();
    check("reset_outputs", {start_ready, result_valid, busy, eq, greater, less}, 6'b100000);
    start_valid = 1'b0;
    reset = 1'b0;
    tick();
    check("no_accept_in_reset", {start_ready, busy}, 2'b10);

    // accept edge puts the block in COMPARE
    a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    check("compare_flags", {start_ready, busy, result_valid}, 3'b010);
    for (int k = 0; k < 8; k++) begin
      if (result_valid !== 1'b1) tick();
    end
    check("compare_done", {result_valid, eq, greater, less, busy}, 5'b11000);
    tick();

    run_cmp("eq_1234",      16'h1234, 16'h1234, 1'b0, 3'b100, 4);
    run_cmp("u_8000_7fff",  16'h8000, 16'h7FFF, 1'b0, 3'b010, 1);
    run_cmp("s_8000_7fff",  16'h8000, 16'h7FFF, 1'b1, 3'b001, 1);
    run_cmp("u_1235_1234",  16'h1235, 16'h1234, 1'b0, 3'b010, 4);
    run_cmp("s_ffff_fffe",  16'hFFFF, 16'hFFFE, 1'b1, 3'b010, 4);
    run_cmp("u_1234_1235",  16'h1234, 16'h1235, 1'b0, 3'b001, 4);
    run_cmp("scramble_f0",  16'h00F0, 16'h00E0, 1'b0, 3'b010, 3);

    // consumer stall: result holds, requests are refused
    start_and_wait(16'h1235, 16'h1234, 1'b0, 1'b0, lat);
    check("stall_lat", lat, 4);
    for (int k = 0; k < 5; k++) begin
      start_valid = k[0] ? 1'b0 : 1'b1;
      a = 16'h0000; b = 16'hFFFF;
      tick();
      check("stall_hold", {result_valid, eq, greater, less, start_ready, busy}, 6'b101000);
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    tick();
    check("stall_release", {result_valid, start_ready, greater}, 3'b010);
    tick();
    check("stall_no_accept", {busy, start_ready}, 2'b01);

    // reset during COMPARE discards the compare
    a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid", {result_valid, busy, start_ready, less}, 4'b0010);
    for (int k = 0; k < 4; k++) tick();
    check("reset_mid_discard", {result_valid, busy}, 2'b00);
    run_cmp("after_reset_3_3", 16'h0003, 16'h0003, 1'b0, 3'b100, 4);

    // reset while DONE with result unaccepted
    start_and_wait(16'h0005, 16'h0005, 1'b0, 1'b0, lat);
    check("done_wait", {result_valid, eq}, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    result_ready = 1'b1;
    check("reset_done", {result_valid, eq, start_ready, busy}, 4'b0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
